// File: rtl/axi_bridge_pkg.sv
// Shared types for the AXI cache bridge: request type encodings, default AXI IDs,
// FSM state encodings and burst-field helpers.
package axi_bridge_pkg;

    localparam logic [2:0] TYPE_BYTE = 3'd0;
    localparam logic [2:0] TYPE_HALF = 3'd1;
    localparam logic [2:0] TYPE_WORD = 3'd2;
    localparam logic [2:0] TYPE_LINE = 3'd4;

    localparam logic [3:0] ID_I_DEF = 4'd0;
    localparam logic [3:0] ID_D_DEF = 4'd1;

    typedef enum logic {
        AR_IDLE,
        AR_SEND
    } ar_state_t;

    typedef enum logic [1:0] {
        W_IDLE,
        W_SEND,
        W_RESP
    } w_state_t;

    function automatic logic [7:0] burst_len(input logic [2:0] rtype, input int beats);
        return (rtype == TYPE_LINE) ? 8'(beats - 1) : 8'd0;
    endfunction

    // Line bursts are always full 32-bit beats; single accesses use the request size.
    function automatic logic [2:0] burst_size(input logic [2:0] rtype);
        return (rtype == TYPE_LINE) ? 3'd2 : {1'b0, rtype[1:0]};
    endfunction

endpackage

// File: rtl/axi_wr_burst.sv
// dcache write path: captures one write, issues AW and W concurrently, then waits for B.
// Exposes the captured address and an outstanding flag for the read-after-write hold.
module axi_wr_burst
    import axi_bridge_pkg::*;
#(
    parameter int         LINE_BEATS = 4,
    parameter logic [3:0] ID_D       = ID_D_DEF
) (
    input  logic          aclk,
    input  logic          aresetn,
    input  logic          wr_req,
    input  logic [2:0]    wr_type,
    input  logic [31:0]   wr_addr,
    input  logic [3:0]    wr_wstrb,
    input  logic [127:0]  wr_data,
    output logic          wr_rdy,
    output logic          wr_done,
    output logic          outstanding,
    output logic [31:0]   write_addr,
    output logic [3:0]    awid,
    output logic [31:0]   awaddr,
    output logic [7:0]    awlen,
    output logic [2:0]    awsize,
    output logic          awvalid,
    input  logic          awready,
    output logic [3:0]    wid,
    output logic [31:0]   wdata,
    output logic [3:0]    wstrb,
    output logic          wlast,
    output logic          wvalid,
    input  logic          wready,
    input  logic [3:0]    bid,
    input  logic          bvalid
);

    localparam int BEAT_W = (LINE_BEATS > 1) ? $clog2(LINE_BEATS) : 1;

    w_state_t            state_reg;
    logic [31:0]         addr_reg;
    logic [2:0]          type_reg;
    logic [3:0]          strb_reg;
    logic [127:0]        data_reg;
    logic                aw_done_reg;
    logic                w_done_reg;
    logic [BEAT_W-1:0]   beat_reg;

    logic is_line;
    logic last_beat;
    logic aw_fin;
    logic w_fin;
    logic b_hit;

    assign is_line   = (type_reg == TYPE_LINE);
    assign last_beat = ~is_line | (beat_reg == BEAT_W'(LINE_BEATS - 1));

    assign awvalid = (state_reg == W_SEND) & ~aw_done_reg;
    assign wvalid  = (state_reg == W_SEND) & ~w_done_reg;

    // Completion includes the handshake happening this cycle so W_RESP is entered
    // before the earliest legal B response.
    assign aw_fin = aw_done_reg | (awvalid & awready);
    assign w_fin  = w_done_reg | (wvalid & wready & last_beat);
    assign b_hit  = (state_reg == W_RESP) & bvalid & (bid == ID_D);

    assign awid    = ID_D;
    assign awaddr  = addr_reg;
    assign awlen   = burst_len(type_reg, LINE_BEATS);
    assign awsize  = burst_size(type_reg);
    assign wid     = ID_D;
    assign wdata   = is_line ? data_reg[32*int'(beat_reg) +: 32] : data_reg[31:0];
    assign wstrb   = is_line ? 4'hF : strb_reg;
    assign wlast   = last_beat;

    assign wr_rdy      = (state_reg == W_IDLE);
    assign wr_done     = b_hit;
    assign outstanding = (state_reg != W_IDLE);
    assign write_addr  = addr_reg;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_reg   <= W_IDLE;
            addr_reg    <= '0;
            type_reg    <= '0;
            strb_reg    <= '0;
            data_reg    <= '0;
            aw_done_reg <= 1'b0;
            w_done_reg  <= 1'b0;
            beat_reg    <= '0;
        end else begin
            case (state_reg)
                W_IDLE: begin
                    if (wr_req) begin
                        addr_reg    <= wr_addr;
                        type_reg    <= wr_type;
                        strb_reg    <= wr_wstrb;
                        data_reg    <= wr_data;
                        aw_done_reg <= 1'b0;
                        w_done_reg  <= 1'b0;
                        beat_reg    <= '0;
                        state_reg   <= W_SEND;
                    end
                end
                W_SEND: begin
                    if (awvalid && awready) begin
                        aw_done_reg <= 1'b1;
                    end
                    if (wvalid && wready) begin
                        if (last_beat) begin
                            w_done_reg <= 1'b1;
                        end else begin
                            beat_reg <= beat_reg + BEAT_W'(1);
                        end
                    end
                    if (aw_fin && w_fin) begin
                        state_reg <= W_RESP;
                    end
                end
                W_RESP: begin
                    if (b_hit) begin
                        state_reg <= W_IDLE;
                    end
                end
                default: state_reg <= W_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/axi_cache_bridge.sv
// Shares one AXI3 master between icache reads and dcache reads/write-backs.
// Define ARB_RR_EN for round-robin AR arbitration; default is dcache-over-icache priority.
module axi_cache_bridge
    import axi_bridge_pkg::*;
#(
    parameter int         LINE_BEATS = 4,
    parameter logic [3:0] ID_I       = ID_I_DEF,
    parameter logic [3:0] ID_D       = ID_D_DEF
) (
    input  logic          aclk,
    input  logic          aresetn,
    input  logic          i_rd_req,
    input  logic [2:0]    i_rd_type,
    input  logic [31:0]   i_rd_addr,
    output logic          i_rd_rdy,
    output logic          i_ret_valid,
    output logic          i_ret_last,
    output logic [31:0]   i_ret_data,
    input  logic          d_rd_req,
    input  logic [2:0]    d_rd_type,
    input  logic [31:0]   d_rd_addr,
    output logic          d_rd_rdy,
    output logic          d_ret_valid,
    output logic          d_ret_last,
    output logic [31:0]   d_ret_data,
    input  logic          d_wr_req,
    input  logic [2:0]    d_wr_type,
    input  logic [31:0]   d_wr_addr,
    input  logic [3:0]    d_wr_wstrb,
    input  logic [127:0]  d_wr_data,
    output logic          d_wr_rdy,
    output logic          d_wr_done,
    output logic [3:0]    arid,
    output logic [31:0]   araddr,
    output logic [7:0]    arlen,
    output logic [2:0]    arsize,
    output logic [1:0]    arburst,
    output logic [1:0]    arlock,
    output logic [3:0]    arcache,
    output logic [2:0]    arprot,
    output logic          arvalid,
    input  logic          arready,
    input  logic [3:0]    rid,
    input  logic [31:0]   rdata,
    input  logic [1:0]    rresp,
    input  logic          rlast,
    input  logic          rvalid,
    output logic          rready,
    output logic [3:0]    awid,
    output logic [31:0]   awaddr,
    output logic [7:0]    awlen,
    output logic [2:0]    awsize,
    output logic [1:0]    awburst,
    output logic [1:0]    awlock,
    output logic [3:0]    awcache,
    output logic [2:0]    awprot,
    output logic          awvalid,
    input  logic          awready,
    output logic [3:0]    wid,
    output logic [31:0]   wdata,
    output logic [3:0]    wstrb,
    output logic          wlast,
    output logic          wvalid,
    input  logic          wready,
    input  logic [3:0]    bid,
    input  logic [1:0]    bresp,
    input  logic          bvalid,
    output logic          bready
);

    localparam int P_I      = 0;
    localparam int P_D      = 1;
    localparam int LINE_LSB = $clog2(LINE_BEATS * 4);

    logic        req_vec   [2];
    logic [2:0]  type_in   [2];
    logic [31:0] addr_in   [2];
    logic        pend_reg  [2];
    logic        busy_reg  [2];
    logic [2:0]  type_reg  [2];
    logic [31:0] addr_reg  [2];
    logic        rdy_vec   [2];
    logic        issue_vec [2];
    logic        ret_hit   [2];

    ar_state_t   ar_state_reg;
    logic        ar_sel_d_reg;
    logic        arvalid_reg;
    logic [3:0]  arid_reg;
    logic [31:0] araddr_reg;
    logic [7:0]  arlen_reg;
    logic [2:0]  arsize_reg;

    logic        wr_outstanding;
    logic [31:0] wr_addr;
    logic        raw_hold;
    logic        d_elig;
    logic        i_elig;
    logic        grant_d;
    logic [2:0]  grant_type;
    logic [31:0] grant_addr;
    logic        unused_resp;

    assign req_vec[P_I] = i_rd_req;
    assign req_vec[P_D] = d_rd_req;
    assign type_in[P_I] = i_rd_type;
    assign type_in[P_D] = d_rd_type;
    assign addr_in[P_I] = i_rd_addr;
    assign addr_in[P_D] = d_rd_addr;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_rd_port
            localparam logic [3:0] PORT_ID = (gi == P_D) ? ID_D : ID_I;

            assign rdy_vec[gi]   = ~pend_reg[gi] & ~busy_reg[gi];
            assign issue_vec[gi] = (ar_state_reg == AR_SEND) & arready
                                   & (ar_sel_d_reg == (gi == P_D));
            // Gating on busy drops beats that belong to a burst abandoned by reset.
            assign ret_hit[gi]   = rvalid & (rid == PORT_ID) & busy_reg[gi];

            always_ff @(posedge aclk or negedge aresetn) begin
                if (!aresetn) begin
                    pend_reg[gi] <= 1'b0;
                    busy_reg[gi] <= 1'b0;
                    type_reg[gi] <= '0;
                    addr_reg[gi] <= '0;
                end else begin
                    if (req_vec[gi] && rdy_vec[gi]) begin
                        pend_reg[gi] <= 1'b1;
                        type_reg[gi] <= type_in[gi];
                        addr_reg[gi] <= addr_in[gi];
                    end else if (issue_vec[gi]) begin
                        pend_reg[gi] <= 1'b0;
                    end
                    if (issue_vec[gi]) begin
                        busy_reg[gi] <= 1'b1;
                    end else if (ret_hit[gi] && rlast) begin
                        busy_reg[gi] <= 1'b0;
                    end
                end
            end
        end
    endgenerate

    assign i_rd_rdy    = rdy_vec[P_I];
    assign d_rd_rdy    = rdy_vec[P_D];
    assign i_ret_valid = ret_hit[P_I];
    assign i_ret_last  = ret_hit[P_I] & rlast;
    assign i_ret_data  = rdata;
    assign d_ret_valid = ret_hit[P_D];
    assign d_ret_last  = ret_hit[P_D] & rlast;
    assign d_ret_data  = rdata;

    // A dcache read may not overtake a write to the same line still awaiting B.
    assign raw_hold = wr_outstanding
                      & (addr_reg[P_D][31:LINE_LSB] == wr_addr[31:LINE_LSB]);
    assign d_elig   = pend_reg[P_D] & ~raw_hold;
    assign i_elig   = pend_reg[P_I];

`ifdef ARB_RR_EN
    logic last_d_reg;

    assign grant_d = d_elig & (~i_elig | ~last_d_reg);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            last_d_reg <= 1'b0;
        end else if (ar_state_reg == AR_SEND && arready) begin
            last_d_reg <= ar_sel_d_reg;
        end
    end
`else
    assign grant_d = d_elig;
`endif

    assign grant_type = grant_d ? type_reg[P_D] : type_reg[P_I];
    assign grant_addr = grant_d ? addr_reg[P_D] : addr_reg[P_I];

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            ar_state_reg <= AR_IDLE;
            ar_sel_d_reg <= 1'b0;
            arvalid_reg  <= 1'b0;
            arid_reg     <= '0;
            araddr_reg   <= '0;
            arlen_reg    <= '0;
            arsize_reg   <= '0;
        end else begin
            case (ar_state_reg)
                AR_IDLE: begin
                    if (d_elig || i_elig) begin
                        ar_sel_d_reg <= grant_d;
                        arvalid_reg  <= 1'b1;
                        arid_reg     <= grant_d ? ID_D : ID_I;
                        araddr_reg   <= grant_addr;
                        arlen_reg    <= burst_len(grant_type, LINE_BEATS);
                        arsize_reg   <= burst_size(grant_type);
                        ar_state_reg <= AR_SEND;
                    end
                end
                AR_SEND: begin
                    if (arready) begin
                        arvalid_reg  <= 1'b0;
                        ar_state_reg <= AR_IDLE;
                    end
                end
                default: ar_state_reg <= AR_IDLE;
            endcase
        end
    end

    assign arid    = arid_reg;
    assign araddr  = araddr_reg;
    assign arlen   = arlen_reg;
    assign arsize  = arsize_reg;
    assign arvalid = arvalid_reg;
    assign arburst = 2'b01;
    assign arlock  = '0;
    assign arcache = '0;
    assign arprot  = '0;
    assign awburst = 2'b01;
    assign awlock  = '0;
    assign awcache = '0;
    assign awprot  = '0;
    assign rready  = 1'b1;
    assign bready  = 1'b1;

    assign unused_resp = ^{rresp, bresp};

    axi_wr_burst #(
        .LINE_BEATS (LINE_BEATS),
        .ID_D       (ID_D)
    ) u_wr (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .wr_req      (d_wr_req),
        .wr_type     (d_wr_type),
        .wr_addr     (d_wr_addr),
        .wr_wstrb    (d_wr_wstrb),
        .wr_data     (d_wr_data),
        .wr_rdy      (d_wr_rdy),
        .wr_done     (d_wr_done),
        .outstanding (wr_outstanding),
        .write_addr  (wr_addr),
        .awid        (awid),
        .awaddr      (awaddr),
        .awlen       (awlen),
        .awsize      (awsize),
        .awvalid     (awvalid),
        .awready     (awready),
        .wid         (wid),
        .wdata       (wdata),
        .wstrb       (wstrb),
        .wlast       (wlast),
        .wvalid      (wvalid),
        .wready      (wready),
        .bid         (bid),
        .bvalid      (bvalid)
    );

endmodule

// File: tb/tb_axi_cache_bridge.sv
// Directed self-checking bench for axi_cache_bridge: line/word reads, ID steering,
// line write-back, read-after-write hold and reset mid-burst.
module tb_axi_cache_bridge;
    import axi_bridge_pkg::*;

    logic         aclk;
    logic         aresetn;
    logic         i_rd_req;
    logic [2:0]   i_rd_type;
    logic [31:0]  i_rd_addr;
    logic         i_rd_rdy;
    logic         i_ret_valid;
    logic         i_ret_last;
    logic [31:0]  i_ret_data;
    logic         d_rd_req;
    logic [2:0]   d_rd_type;
    logic [31:0]  d_rd_addr;
    logic         d_rd_rdy;
    logic         d_ret_valid;
    logic         d_ret_last;
    logic [31:0]  d_ret_data;
    logic         d_wr_req;
    logic [2:0]   d_wr_type;
    logic [31:0]  d_wr_addr;
    logic [3:0]   d_wr_wstrb;
    logic [127:0] d_wr_data;
    logic         d_wr_rdy;
    logic         d_wr_done;
    logic [3:0]   arid;
    logic [31:0]  araddr;
    logic [7:0]   arlen;
    logic [2:0]   arsize;
    logic [1:0]   arburst;
    logic [1:0]   arlock;
    logic [3:0]   arcache;
    logic [2:0]   arprot;
    logic         arvalid;
    logic         arready;
    logic [3:0]   rid;
    logic [31:0]  rdata;
    logic [1:0]   rresp;
    logic         rlast;
    logic         rvalid;
    logic         rready;
    logic [3:0]   awid;
    logic [31:0]  awaddr;
    logic [7:0]   awlen;
    logic [2:0]   awsize;
    logic [1:0]   awburst;
    logic [1:0]   awlock;
    logic [3:0]   awcache;
    logic [2:0]   awprot;
    logic         awvalid;
    logic         awready;
    logic [3:0]   wid;
    logic [31:0]  wdata;
    logic [3:0]   wstrb;
    logic         wlast;
    logic         wvalid;
    logic         wready;
    logic [3:0]   bid;
    logic [1:0]   bresp;
    logic         bvalid;
    logic         bready;

    int checks   = 0;
    int failures = 0;
    logic [127:0] line_data;

    axi_cache_bridge dut (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .i_rd_req    (i_rd_req),
        .i_rd_type   (i_rd_type),
        .i_rd_addr   (i_rd_addr),
        .i_rd_rdy    (i_rd_rdy),
        .i_ret_valid (i_ret_valid),
        .i_ret_last  (i_ret_last),
        .i_ret_data  (i_ret_data),
        .d_rd_req    (d_rd_req),
        .d_rd_type   (d_rd_type),
        .d_rd_addr   (d_rd_addr),
        .d_rd_rdy    (d_rd_rdy),
        .d_ret_valid (d_ret_valid),
        .d_ret_last  (d_ret_last),
        .d_ret_data  (d_ret_data),
        .d_wr_req    (d_wr_req),
        .d_wr_type   (d_wr_type),
        .d_wr_addr   (d_wr_addr),
        .d_wr_wstrb  (d_wr_wstrb),
        .d_wr_data   (d_wr_data),
        .d_wr_rdy    (d_wr_rdy),
        .d_wr_done   (d_wr_done),
        .arid        (arid),
        .araddr      (araddr),
        .arlen       (arlen),
        .arsize      (arsize),
        .arburst     (arburst),
        .arlock      (arlock),
        .arcache     (arcache),
        .arprot      (arprot),
        .arvalid     (arvalid),
        .arready     (arready),
        .rid         (rid),
        .rdata       (rdata),
        .rresp       (rresp),
        .rlast       (rlast),
        .rvalid      (rvalid),
        .rready      (rready),
        .awid        (awid),
        .awaddr      (awaddr),
        .awlen       (awlen),
        .awsize      (awsize),
        .awburst     (awburst),
        .awlock      (awlock),
        .awcache     (awcache),
        .awprot      (awprot),
        .awvalid     (awvalid),
        .awready     (awready),
        .wid         (wid),
        .wdata       (wdata),
        .wstrb       (wstrb),
        .wlast       (wlast),
        .wvalid      (wvalid),
        .wready      (wready),
        .bid         (bid),
        .bresp       (bresp),
        .bvalid      (bvalid),
        .bready      (bready)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_arvalid(input string tag);
        int n;
        n = 0;
        while (arvalid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk(tag, arvalid, 1);
    endtask

    task automatic ar_handshake();
        arready = 1'b1;
        tick();
        arready = 1'b0;
    endtask

    initial begin
        logic [3:0] id_seen;
        aresetn = 1'b0;
        i_rd_req = 0; i_rd_type = 0; i_rd_addr = 0;
        d_rd_req = 0; d_rd_type = 0; d_rd_addr = 0;
        d_wr_req = 0; d_wr_type = 0; d_wr_addr = 0; d_wr_wstrb = 0; d_wr_data = 0;
        arready = 0; awready = 0; wready = 0;
        rid = 0; rdata = 0; rresp = 0; rlast = 0; rvalid = 0;
        bid = 0; bresp = 0; bvalid = 0;
        line_data = 128'h40414243_30313233_20212223_10111213;
        tick(); tick();

        // Reset state
        chk("rst_arvalid", arvalid, 0);
        chk("rst_awvalid", awvalid, 0);
        chk("rst_wvalid", wvalid, 0);
        chk("rst_i_rdy", i_rd_rdy, 1);
        chk("rst_d_rdy", d_rd_rdy, 1);
        chk("rst_wr_rdy", d_wr_rdy, 1);
        chk("rst_rready", rready, 1);
        chk("rst_bready", bready, 1);
        chk("rst_wr_done", d_wr_done, 0);
        chk("rst_i_ret_valid", i_ret_valid, 0);
        aresetn = 1'b1;
        tick();

        // T1: icache line read
        i_rd_req = 1; i_rd_type = TYPE_LINE; i_rd_addr = 32'h1C000010;
        tick();
        i_rd_req = 0;
        wait_arvalid("t1_arvalid");
        chk("t1_araddr", araddr, 32'h1C000010);
        chk("t1_arid", arid, 0);
        chk("t1_arlen", arlen, 3);
        chk("t1_arsize", arsize, 2);
        chk("t1_arburst", arburst, 1);
        ar_handshake();
        chk("t1_arvalid_drop", arvalid, 0);
        chk("t1_i_rdy_busy", i_rd_rdy, 0);
        for (int k = 0; k < 4; k++) begin
            rvalid = 1; rid = 0; rdata = 32'hA0 + k; rlast = (k == 3);
            #1;
            chk("t1_ret_valid", i_ret_valid, 1);
            chk("t1_ret_data", i_ret_data, 32'hA0 + k);
            chk("t1_ret_last", i_ret_last, (k == 3));
            chk("t1_d_ret_quiet", d_ret_valid, 0);
            tick();
        end
        rvalid = 0; rlast = 0;
        chk("t1_i_rdy_back", i_rd_rdy, 1);

        // T2: simultaneous word reads, dcache first, out-of-order R by ID
        i_rd_req = 1; i_rd_type = TYPE_WORD; i_rd_addr = 32'h20000004;
        d_rd_req = 1; d_rd_type = TYPE_WORD; d_rd_addr = 32'h30000008;
        chk("t2_i_rdy", i_rd_rdy, 1);
        chk("t2_d_rdy", d_rd_rdy, 1);
        tick();
        i_rd_req = 0; d_rd_req = 0;
        wait_arvalid("t2_ar1");
        chk("t2_ar1_id", arid, 1);
        chk("t2_ar1_addr", araddr, 32'h30000008);
        chk("t2_ar1_len", arlen, 0);
        chk("t2_ar1_size", arsize, 2);
        ar_handshake();
        wait_arvalid("t2_ar2");
        chk("t2_ar2_id", arid, 0);
        chk("t2_ar2_addr", araddr, 32'h20000004);
        ar_handshake();
        rvalid = 1; rid = 0; rdata = 32'h00001111; rlast = 1;
        #1;
        chk("t2_r0_i_valid", i_ret_valid, 1);
        chk("t2_r0_d_valid", d_ret_valid, 0);
        chk("t2_r0_data", i_ret_data, 32'h00001111);
        tick();
        rid = 1; rdata = 32'h00002222;
        #1;
        chk("t2_r1_d_valid", d_ret_valid, 1);
        chk("t2_r1_i_valid", i_ret_valid, 0);
        chk("t2_r1_d_last", d_ret_last, 1);
        chk("t2_r1_data", d_ret_data, 32'h00002222);
        tick();
        rvalid = 0; rlast = 0;
        chk("t2_i_rdy_back", i_rd_rdy, 1);
        chk("t2_d_rdy_back", d_rd_rdy, 1);

        // T3: dcache line write, AW accepted late
        d_wr_req = 1; d_wr_type = TYPE_LINE; d_wr_addr = 32'h80;
        d_wr_wstrb = 4'h3; d_wr_data = line_data;
        chk("t3_wr_rdy", d_wr_rdy, 1);
        tick();
        d_wr_req = 0;
        chk("t3_wr_rdy_busy", d_wr_rdy, 0);
        chk("t3_awaddr", awaddr, 32'h80);
        chk("t3_awlen", awlen, 3);
        chk("t3_awsize", awsize, 2);
        chk("t3_awid", awid, 1);
        for (int k = 0; k < 4; k++) begin
            awready = (k == 2); wready = 1;
            #1;
            chk("t3_awvalid", awvalid, (k < 3));
            chk("t3_wvalid", wvalid, 1);
            chk("t3_wdata", wdata, line_data[k*32 +: 32]);
            chk("t3_wstrb", wstrb, 4'hF);
            chk("t3_wlast", wlast, (k == 3));
            chk("t3_wid", wid, 1);
            tick();
        end
        awready = 0; wready = 0;
        chk("t3_wvalid_done", wvalid, 0);
        chk("t3_awvalid_done", awvalid, 0);
        chk("t3_no_early_done", d_wr_done, 0);
        tick();
        bvalid = 1; bid = 1;
        #1;
        chk("t3_wr_done", d_wr_done, 1);
        tick();
        bvalid = 0;
        chk("t3_wr_done_pulse", d_wr_done, 0);
        chk("t3_wr_rdy_back", d_wr_rdy, 1);

        // T4: RAW hold on dcache read, icache bypasses it
        d_wr_req = 1; d_wr_type = TYPE_WORD; d_wr_addr = 32'h100;
        d_wr_wstrb = 4'h5; d_wr_data = 128'hDEADBEEF;
        tick();
        d_wr_req = 0;
        chk("t4_awlen", awlen, 0);
        chk("t4_wstrb", wstrb, 4'h5);
        chk("t4_wlast", wlast, 1);
        chk("t4_wdata", wdata, 32'hDEADBEEF);
        d_rd_req = 1; d_rd_type = TYPE_WORD; d_rd_addr = 32'h108;
        tick();
        d_rd_req = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("t4_held", arvalid, 0);
        end
        i_rd_req = 1; i_rd_type = TYPE_WORD; i_rd_addr = 32'h200;
        tick();
        i_rd_req = 0;
        wait_arvalid("t4_i_ar");
        chk("t4_i_arid", arid, 0);
        chk("t4_i_araddr", araddr, 32'h200);
        ar_handshake();
        rvalid = 1; rid = 0; rlast = 1; rdata = 32'h5;
        tick();
        rvalid = 0; rlast = 0;
        awready = 1; wready = 1;
        tick();
        awready = 0; wready = 0;
        chk("t4_held_resp", arvalid, 0);
        bvalid = 1; bid = 1;
        #1;
        chk("t4_wr_done", d_wr_done, 1);
        chk("t4_held_b", arvalid, 0);
        tick();
        bvalid = 0;
        chk("t4_held_release", arvalid, 0);
        tick();
        chk("t4_d_ar", arvalid, 1);
        chk("t4_d_arid", arid, 1);
        chk("t4_d_araddr", araddr, 32'h108);
        ar_handshake();
        rvalid = 1; rid = 1; rlast = 1; rdata = 32'h6;
        tick();
        rvalid = 0; rlast = 0;
        chk("t4_d_rdy_back", d_rd_rdy, 1);

        // T5: reset mid-burst, then a fresh read
        i_rd_req = 1; i_rd_type = TYPE_LINE; i_rd_addr = 32'h400;
        tick();
        i_rd_req = 0;
        wait_arvalid("t5_ar");
        ar_handshake();
        for (int k = 0; k < 2; k++) begin
            rvalid = 1; rid = 0; rlast = 0; rdata = 32'hC0 + k;
            #1;
            chk("t5_beat", i_ret_valid, 1);
            tick();
        end
        rdata = 32'hC2;
        aresetn = 0;
        #1;
        chk("t5_rst_arvalid", arvalid, 0);
        chk("t5_rst_i_rdy", i_rd_rdy, 1);
        chk("t5_rst_d_rdy", d_rd_rdy, 1);
        chk("t5_rst_wr_rdy", d_wr_rdy, 1);
        chk("t5_rst_drop", i_ret_valid, 0);
        tick();
        aresetn = 1;
        rdata = 32'hC3; rlast = 1;
        #1;
        chk("t5_drop_tail", i_ret_valid, 0);
        chk("t5_drop_last", i_ret_last, 0);
        tick();
        rvalid = 0; rlast = 0;
        d_rd_req = 1; d_rd_type = TYPE_BYTE; d_rd_addr = 32'h501;
        tick();
        d_rd_req = 0;
        wait_arvalid("t5_fresh_ar");
        chk("t5_fresh_arid", arid, 1);
        chk("t5_fresh_araddr", araddr, 32'h501);
        chk("t5_fresh_arsize", arsize, 0);
        chk("t5_fresh_arlen", arlen, 0);
        ar_handshake();
        rvalid = 1; rid = 1; rlast = 1; rdata = 32'h77;
        #1;
        chk("t5_fresh_valid", d_ret_valid, 1);
        chk("t5_fresh_data", d_ret_data, 32'h77);
        chk("t5_fresh_last", d_ret_last, 1);
        tick();
        rvalid = 0; rlast = 0;
        chk("t5_fresh_rdy", d_rd_rdy, 1);

`ifdef ARB_RR_EN
        // T6: continuous requests from both ports alternate AR IDs
        aresetn = 0;
        tick();
        aresetn = 1;
        i_rd_req = 1; i_rd_type = TYPE_WORD; i_rd_addr = 32'h600;
        d_rd_req = 1; d_rd_type = TYPE_WORD; d_rd_addr = 32'h700;
        for (int g = 0; g < 4; g++) begin
            wait_arvalid("t6_ar");
            chk("t6_arid", arid, (g % 2 == 0) ? 4'd1 : 4'd0);
            id_seen = arid;
            ar_handshake();
            rvalid = 1; rid = id_seen; rlast = 1; rdata = 32'h60 + g;
            tick();
            rvalid = 0; rlast = 0;
        end
        i_rd_req = 0; d_rd_req = 0;
        aresetn = 0;
        tick();
        aresetn = 1;
`else
        id_seen = 4'd0;
`endif
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
